ttt_ctrl: RTL
=============

# ttt_ctrl

Game sequencer for the `ttt` tic-tac-toe core. It accepts move requests from two player channels over valid/ready handshakes and validates each one for range, cell occupancy and turn order. Each accepted move is issued to the core as a single enable pulse. After every move it evaluates the core's flattened board for a win or draw, and it enforces a per-turn timeout.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles allowed in WAIT_MOVE before the player on turn forfeits. 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new game. Honoured only in IDLE or DONE.
- `p0_valid`, `p1_valid` in 1: move request.
- `p0_x`, `p0_y`, `p1_x`, `p1_y` in 3: requested cell coordinates.
- `p0_ready`, `p1_ready` out 1: request consumed this cycle when valid && ready.
- `core_reset` out 1: drives the core `reset`.
- `core_enable` out 1: drives the core `enable`.
- `core_x`, `core_y` out 3: drive the core `data_in_x` / `data_in_y`.
- `core_board` in 18: core `board`. Cell (x,y) is `[2*(y*3+x) +: 2]`; 2 = empty, 0 = player 0, 1 = player 1.
- `turn` out 1: player whose move is expected.
- `move_count` out 4: accepted moves this game, 0..9.
- `game_over` out 1: high in DONE.
- `result` out 2: 0 = none, 1 = player 0 wins, 2 = player 1 wins, 3 = draw.
- `forfeit` out 1: result was caused by timeout.
- `reject` out 1: one-cycle pulse when a consumed request is refused.
- `reject_code` out 2: 1 = out of range, 2 = occupied, 3 = not your turn. Held until the next reject.

## Operation
- **States:** IDLE, CLEAR, WAIT_MOVE, ISSUE, CHECK, DONE.
- **Reset:** state IDLE. All outputs 0 except `core_reset`.
- **`core_reset`:** `reset | (state==CLEAR)`, combinational.
- **IDLE / DONE:** on `start`, go to CLEAR. Entering CLEAR zeroes `turn`, `move_count`, `result`, `forfeit` and `reject_code`.
- **CLEAR:** one cycle, then WAIT_MOVE. The core is then all-empty with core player 0.
- **WAIT_MOVE, readies:**
  - On-turn ready = 1.
  - Off-turn ready = !on-turn valid. If both players are valid, the on-turn request is consumed and the off-turn request stalls.
- **WAIT_MOVE, consumed off-turn request:** `reject`, code 3.
- **WAIT_MOVE, consumed on-turn request:**
  - x>2 or y>2: `reject`, code 1.
  - Target cell in `core_board` != 2: `reject`, code 2.
  - Otherwise: latch x/y into `core_x`/`core_y` and go to ISSUE.
- **Rejects:** leave the state, `turn` and the timeout counter unchanged.
- **Timeout:** counter clears on entry to WAIT_MOVE and increments each WAIT_MOVE cycle. When it reaches `TIMEOUT_CYCLES` with no accept, go to DONE with `result` = opponent+1 and `forfeit`=1.
- **ISSUE:** `core_enable`=1 for exactly one cycle, then CHECK. `core_enable` is never high in any other state, so the core's player stays equal to `turn`.
- **CHECK:**
  - Increment `move_count`.
  - Test the 8 lines (3 rows, 3 columns, 2 diagonals) on `core_board` for value == `turn`. On a hit, go to DONE with `result`=`turn`+1.
  - Else if the new count == 9, go to DONE with `result`=3.
  - Else toggle `turn` and go to WAIT_MOVE.
- **DONE:** `game_over`=1. Readies are 0; requests are not consumed. Outputs hold until `start` or `reset`.
- **Readies** are 0 in every state except WAIT_MOVE.
- **Timeout width:** counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
- **Reset mid-game:** takes effect next edge from any state; an in-flight ISSUE is dropped.

## Timing
- `start` sampled at edge S: CLEAR in cycle S+1, readies high in S+2.
- Accept at edge A:
  - `core_enable` high in cycle A+1.
  - CHECK in A+2, reading the updated board.
  - Next ready, or `game_over`, in A+3.
- Throughput: one move per 3 cycles.
- `reject` is asserted in the cycle after the consuming edge; the state is unchanged.
- Timeout fires `TIMEOUT_CYCLES` cycles after entering WAIT_MOVE; `game_over` is high the following cycle.

## Test plan
- **Player 0 wins:** reset, start; p0 (0,0), p1 (1,0), p0 (0,1), p1 (1,1), p0 (0,2) -> `result`=1, `game_over`=1, `move_count`=5, `core_board[1:0]`=0, five `core_enable` pulses total.
- **Occupied cell:** p0 (1,1), then p1 (1,1) -> `reject`, code 2, `turn` stays 1, no `core_enable` pulse; p1 (2,2) is then accepted.
- **Range and turn checks:** p0 x=3 -> code 1. p1 valid while `turn`=0 and p0 idle -> consumed, code 3. Both valid -> p0 consumed and p1 stalled (`p1_ready`=0).
- **Draw:** moves, alternating from p0: (0,0) (1,0) (2,0) (1,1) (0,1) (2,1) (1,2) (0,2) (2,2) -> `result`=3, `move_count`=9.
- **Timeout:** `TIMEOUT_CYCLES`=8, start, no valid for 8 cycles -> `result`=2, `forfeit`=1. A rejected request in between does not extend the deadline.
- **Reset mid-game:** reset asserted during ISSUE -> next cycle IDLE, all outputs 0, `core_reset`=1. After start, `core_board` = all cells 2.

Source files
------------

// File: rtl/ttt_ctrl.sv
// ttt_ctrl: game sequencer for the ttt tic-tac-toe core.
//
// Accepts move requests from two player channels (valid/ready), validates
// range, occupancy and turn order, issues each accepted move to the core as a
// one-cycle enable pulse, then scores the core board for a win or draw.
// A per-turn timeout forfeits the player on turn.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a new game (honoured in IDLE / DONE)
//   p0_*/p1_*               player request channels (valid, x, y, ready)
//   core_reset/core_enable  core control; core_x/core_y move coordinates
//   core_board              flattened core board, cell (x,y) at [2*(3y+x) +: 2]
//   turn, move_count        player on turn, accepted moves this game
//   game_over, result       DONE flag; 0 none, 1 p0, 2 p1, 3 draw
//   forfeit                 result came from a timeout
//   reject, reject_code     refusal pulse; 1 range, 2 occupied, 3 not your turn
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_CLEAR   | core held in reset for one cycle
// S_WAIT    | waiting for a move from the player on turn, timeout running
// S_ISSUE   | core_enable pulse for the latched move
// S_CHECK   | score the updated board, advance turn or finish
// S_DONE    | game finished, outputs held until start

module ttt_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        p0_valid,
    input  logic [2:0]  p0_x,
    input  logic [2:0]  p0_y,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [2:0]  p1_x,
    input  logic [2:0]  p1_y,
    output logic        p1_ready,
    output logic        core_reset,
    output logic        core_enable,
    output logic [2:0]  core_x,
    output logic [2:0]  core_y,
    input  logic [17:0] core_board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic [1:0]  result,
    output logic        forfeit,
    output logic        reject,
    output logic [1:0]  reject_code
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_ISSUE, S_CHECK, S_DONE} state_t;

    // A zero timeout still needs a one-bit counter; it simply never advances.
    localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TLAST_I   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TLAST_I);

    state_t         state_q;
    logic           turn_q;
    logic [3:0]     move_count_q;
    logic [1:0]     result_q;
    logic           forfeit_q;
    logic           reject_q;
    logic [1:0]     reject_code_q;
    logic [2:0]     core_x_q;
    logic [2:0]     core_y_q;
    logic [TW-1:0]  tmo_q;

    logic           in_wait;
    logic           on_valid;
    logic           off_valid;
    logic [2:0]     on_x;
    logic [2:0]     on_y;
    logic           on_take;
    logic           off_take;
    logic           in_range;
    logic [3:0]     cell_idx;
    logic [1:0]     cell_sel;
    logic [1:0]     c [9];
    logic [1:0]     pv;
    logic           win;
    logic           accept;
    logic           tmo_hit;
    logic [3:0]     move_count_d;

    assign in_wait   = (state_q == S_WAIT);
    assign on_valid  = turn_q ? p1_valid : p0_valid;
    assign off_valid = turn_q ? p0_valid : p1_valid;
    assign on_x      = turn_q ? p1_x : p0_x;
    assign on_y      = turn_q ? p1_y : p0_y;

    // The on-turn player always wins arbitration; the other side stalls.
    assign p0_ready  = in_wait && (!turn_q || !p1_valid);
    assign p1_ready  = in_wait && ( turn_q || !p0_valid);
    assign on_take   = in_wait && on_valid;
    assign off_take  = in_wait && off_valid && !on_valid;

    assign in_range  = (on_x <= 3'd2) && (on_y <= 3'd2);
    assign cell_idx  = 4'(on_y) * 4'd3 + 4'(on_x);

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            c[i] = core_board[2*i +: 2];
        end
    end

    always_comb begin
        cell_sel = 2'd2;
        for (int i = 0; i < 9; i++) begin
            if (in_range && cell_idx == 4'(i)) begin
                cell_sel = c[i];
            end
        end
    end

    assign accept = on_take && in_range && (cell_sel == 2'd2);

    assign pv  = {1'b0, turn_q};
    assign win = (c[0] == pv && c[1] == pv && c[2] == pv) ||
                 (c[3] == pv && c[4] == pv && c[5] == pv) ||
                 (c[6] == pv && c[7] == pv && c[8] == pv) ||
                 (c[0] == pv && c[3] == pv && c[6] == pv) ||
                 (c[1] == pv && c[4] == pv && c[7] == pv) ||
                 (c[2] == pv && c[5] == pv && c[8] == pv) ||
                 (c[0] == pv && c[4] == pv && c[8] == pv) ||
                 (c[2] == pv && c[4] == pv && c[6] == pv);

    // Fires on the last allowed WAIT cycle, so DONE follows TIMEOUT_CYCLES
    // WAIT cycles after entry.
    assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    assign move_count_d = move_count_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            turn_q        <= 1'b0;
            move_count_q  <= 4'd0;
            result_q      <= 2'd0;
            forfeit_q     <= 1'b0;
            reject_q      <= 1'b0;
            reject_code_q <= 2'd0;
            core_x_q      <= 3'd0;
            core_y_q      <= 3'd0;
            tmo_q         <= '0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_CLEAR;
                        turn_q        <= 1'b0;
                        move_count_q  <= 4'd0;
                        result_q      <= 2'd0;
                        forfeit_q     <= 1'b0;
                        reject_code_q <= 2'd0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_WAIT;
                    tmo_q   <= '0;
                end
                S_WAIT: begin
                    if (tmo_q != TMO_MAX) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (off_take || (on_take && !accept)) begin
                        reject_q      <= 1'b1;
                        reject_code_q <= off_take ? 2'd3 : (!in_range ? 2'd1 : 2'd2);
                    end
                    if (accept) begin
                        core_x_q <= on_x;
                        core_y_q <= on_y;
                        state_q  <= S_ISSUE;
                    end else if (tmo_hit) begin
                        state_q   <= S_DONE;
                        result_q  <= turn_q ? 2'd1 : 2'd2;
                        forfeit_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    move_count_q <= move_count_d;
                    if (win) begin
                        state_q  <= S_DONE;
                        result_q <= {turn_q, ~turn_q};
                    end else if (move_count_d == 4'd9) begin
                        state_q  <= S_DONE;
                        result_q <= 2'd3;
                    end else begin
                        state_q <= S_WAIT;
                        turn_q  <= ~turn_q;
                        tmo_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_reset  = reset | (state_q == S_CLEAR);
    assign core_enable = (state_q == S_ISSUE);
    assign core_x      = core_x_q;
    assign core_y      = core_y_q;
    assign turn        = turn_q;
    assign move_count  = move_count_q;
    assign game_over   = (state_q == S_DONE);
    assign result      = result_q;
    assign forfeit     = forfeit_q;
    assign reject      = reject_q;
    assign reject_code = reject_code_q;

endmodule
